// File: rtl/temp_bcd_sampler.sv
// temp_bcd_sampler
//   Accepts signed binary temperature samples (tenths of a degree) over a
//   valid/ready handshake. Converts |sample| and the signed change from the
//   previously accepted sample into 3-digit BCD with a 10-cycle shift-add-3
//   engine. All results are presented together, qualified by a one-cycle
//   out_valid strobe. The outputs hold their values until the next strobe.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   sample_valid/ready/data   input handshake; ready is high only in IDLE
//   temp_value_{huns,tens,ones}, temp_value_sign
//                             BCD magnitude of the sample and its sign
//   temp_delta_{huns,tens,ones}, temp_delta_sign
//                             BCD magnitude of (sample - previous); the sign
//                             is 1 when the temperature decreased
//   first_sample              outputs come from the first sample since reset
//   sat                       value or delta was clamped to SAT_LIMIT
//   out_valid                 one-cycle update strobe
module temp_bcd_sampler #(
  parameter int SAMPLE_W  = 11,
  parameter int SAT_LIMIT = 999
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic signed [SAMPLE_W-1:0] sample_data,
  output logic [3:0]                 temp_value_ones,
  output logic [3:0]                 temp_value_tens,
  output logic [3:0]                 temp_value_huns,
  output logic                       temp_value_sign,
  output logic [3:0]                 temp_delta_ones,
  output logic [3:0]                 temp_delta_tens,
  output logic [3:0]                 temp_delta_huns,
  output logic                       temp_delta_sign,
  output logic                       first_sample,
  output logic                       sat,
  output logic                       out_valid
);

  // One extra bit so that |most negative sample| and the full-range
  // difference of two samples are both representable.
  localparam int XW = SAMPLE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PREP  = 2'd1,
    S_SHIFT = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Clamp a magnitude to SAT_LIMIT; the comparison is done at 32 bits so it
  // is independent of XW.
  function automatic logic [9:0] clamp_mag(input logic [XW-1:0] m);
    logic [31:0] m32;
    m32 = 32'(m);
    if (m32 > 32'(SAT_LIMIT)) return 10'(SAT_LIMIT);
    else                      return 10'(m);
  endfunction

  function automatic logic was_clamped(input logic [XW-1:0] m);
    return 32'(m) > 32'(SAT_LIMIT);
  endfunction

  // One double-dabble step on {bcd[11:0], bin[9:0]}: correct every BCD
  // nibble that would overflow on doubling, then shift left by one.
  function automatic logic [21:0] dd_step(input logic [21:0] c);
    logic [21:0] t;
    t = c;
    for (int i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  state_t state_q, state_d;

  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic signed [SAMPLE_W-1:0] prev_q, prev_d;
  logic                       first_q, first_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [21:0]                vconv_q, vconv_d;
  logic [21:0]                dconv_q, dconv_d;
  logic                       dsign_q, dsign_d;
  logic                       satp_q, satp_d;

  logic [11:0]                val_bcd_q, val_bcd_d;
  logic [11:0]                dlt_bcd_q, dlt_bcd_d;
  logic                       val_sign_q, val_sign_d;
  logic                       dlt_sign_q, dlt_sign_d;
  logic                       sat_q, sat_d;
  logic                       first_out_q, first_out_d;
  logic                       out_valid_q, out_valid_d;

  logic                       accept;
  logic signed [XW-1:0]       s_ext, p_ext, diff;
  logic [XW-1:0]              mag, dmag;
  logic                       dneg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_valid) state_d = S_PREP;
      S_PREP:  state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == 4'd9) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sample_ready = (state_q == S_IDLE);
  end

  assign accept = sample_valid && sample_ready;

  // ------------------------------------------- PREP: magnitude and delta
  always_comb begin
    s_ext = {sample_q[SAMPLE_W-1], sample_q};
    p_ext = {prev_q[SAMPLE_W-1], prev_q};
    diff  = s_ext - p_ext;
    mag   = s_ext[XW-1] ? -s_ext : s_ext;
    dneg  = diff[XW-1] && !first_q;
    if (first_q)      dmag = '0;
    else if (dneg)    dmag = -diff;
    else              dmag = diff;
  end

  // ---------------------------------------- datapath next-state selection
  always_comb begin
    sample_d    = sample_q;
    prev_d      = prev_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    vconv_d     = vconv_q;
    dconv_d     = dconv_q;
    dsign_d     = dsign_q;
    satp_d      = satp_q;
    val_bcd_d   = val_bcd_q;
    dlt_bcd_d   = dlt_bcd_q;
    val_sign_d  = val_sign_q;
    dlt_sign_d  = dlt_sign_q;
    sat_d       = sat_q;
    first_out_d = first_out_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) sample_d = sample_data;
      end
      S_PREP: begin
        vconv_d = {12'd0, clamp_mag(mag)};
        dconv_d = {12'd0, clamp_mag(dmag)};
        dsign_d = dneg;
        satp_d  = was_clamped(mag) || was_clamped(dmag);
        cnt_d   = 4'd0;
      end
      // SHIFT: both converters advance one bit per cycle, 10 cycles total.
      S_SHIFT: begin
        vconv_d = dd_step(vconv_q);
        dconv_d = dd_step(dconv_q);
        cnt_d   = cnt_q + 4'd1;
      end
      S_OUT: begin
        val_bcd_d   = vconv_q[21:10];
        dlt_bcd_d   = dconv_q[21:10];
        val_sign_d  = sample_q[SAMPLE_W-1];
        dlt_sign_d  = dsign_q;
        sat_d       = satp_q;
        first_out_d = first_q;
        out_valid_d = 1'b1;
        // prev keeps the raw, unclamped sample so later deltas stay exact.
        prev_d      = sample_q;
        first_d     = 1'b0;
      end
      default: ;
    endcase
  end

  // Working registers of the converter carry no reset: they are always
  // reloaded in PREP before being used.
  always_ff @(posedge clk) begin
    sample_q <= sample_d;
    vconv_q  <= vconv_d;
    dconv_q  <= dconv_d;
    dsign_q  <= dsign_d;
    satp_q   <= satp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      first_q     <= 1'b1;
      cnt_q       <= 4'd0;
      val_bcd_q   <= '0;
      dlt_bcd_q   <= '0;
      val_sign_q  <= 1'b0;
      dlt_sign_q  <= 1'b0;
      sat_q       <= 1'b0;
      first_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      val_bcd_q   <= val_bcd_d;
      dlt_bcd_q   <= dlt_bcd_d;
      val_sign_q  <= val_sign_d;
      dlt_sign_q  <= dlt_sign_d;
      sat_q       <= sat_d;
      first_out_q <= first_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign temp_value_huns = val_bcd_q[11:8];
  assign temp_value_tens = val_bcd_q[7:4];
  assign temp_value_ones = val_bcd_q[3:0];
  assign temp_value_sign = val_sign_q;
  assign temp_delta_huns = dlt_bcd_q[11:8];
  assign temp_delta_tens = dlt_bcd_q[7:4];
  assign temp_delta_ones = dlt_bcd_q[3:0];
  assign temp_delta_sign = dlt_sign_q;
  assign first_sample    = first_out_q;
  assign sat             = sat_q;
  assign out_valid       = out_valid_q;

endmodule
